// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store front end for dmemory32.
// Sub-word stores are read-modify-write; misaligned requests never reach memory.
module mem_access_unit #(
  parameter int MEM_AW = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, ERR, WR, ISSUE, CAPTURE, MERGE, RESP
  } state_t;

  state_t      state, stateNext;
  logic        rqWrite;
  logic [1:0]  rqSize;
  logic        rqUnsigned;
  logic [1:0]  rqLane;
  logic [15:0] rqWdata;
  logic [31:0] capWord;

  logic        accept;
  logic        misaligned;
  logic        wordStore;
  logic [7:0]  capByte;
  logic [15:0] capHalf;
  logic [31:0] loadData;
  logic [31:0] mergeWord;
  logic        unusedAddr;

  // Upper address bits alias onto the same memory words.
  assign unusedAddr = ^req_addr[31:MEM_AW+2];

  assign accept    = req_valid && req_ready;
  assign wordStore = req_write && (req_size == 2'd2);

  always_comb begin
    misaligned = 1'b1;
    unique case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)     stateNext = ERR;
          else if (wordStore) stateNext = WR;
          else                stateNext = ISSUE;
        end
      end
      ERR:     stateNext = IDLE;
      WR:      stateNext = RESP;
      ISSUE:   stateNext = CAPTURE;
      CAPTURE: stateNext = rqWrite ? MERGE : RESP;
      MERGE:   stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    capByte  = capWord[{rqLane, 3'b000} +: 8];
    capHalf  = rqLane[1] ? capWord[31:16] : capWord[15:0];
    loadData = capWord;
    unique case (rqSize)
      2'd0:    loadData = {{24{capByte[7] & ~rqUnsigned}}, capByte};
      2'd1:    loadData = {{16{capHalf[15] & ~rqUnsigned}}, capHalf};
      default: loadData = capWord;
    endcase
  end

  // Merge straight from the read port so the write lands the cycle after.
  always_comb begin
    mergeWord = mem_rdata;
    if (rqSize == 2'd0)
      mergeWord[{rqLane, 3'b000} +: 8] = rqWdata[7:0];
    else
      mergeWord[{rqLane[1], 4'b0000} +: 16] = rqWdata;
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == ERR) || (state == RESP);
  assign rsp_err   = (state == ERR);
  assign rsp_rdata = (state == RESP && !rqWrite) ? loadData : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
      rqWrite    <= 1'b0;
      rqSize     <= '0;
      rqUnsigned <= 1'b0;
      rqLane     <= '0;
      rqWdata    <= '0;
      capWord    <= '0;
    end else begin
      state     <= stateNext;
      mem_write <= 1'b0;
      if (accept) begin
        rqWrite    <= req_write;
        rqSize     <= req_size;
        rqUnsigned <= req_unsigned;
        rqLane     <= req_addr[1:0];
        rqWdata    <= req_wdata[15:0];
        if (!misaligned)
          mem_addr <= req_addr[MEM_AW+1:2];
        if (!misaligned && wordStore) begin
          mem_wdata <= req_wdata;
          mem_write <= 1'b1;
        end
      end
      if (state == CAPTURE) begin
        capWord <= mem_rdata;
        if (rqWrite) begin
          mem_wdata <= mergeWord;
          mem_write <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store traffic
// against a word-memory shadow with arithmetic lane rules.
module tb_mem_access_unit;
  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_write;
  logic [31:0]   mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] dmem [0:(1<<AW)-1];
  logic [31:0] shadow [int];

  mem_access_unit #(.MEM_AW(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= dmem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widthOf(input logic [1:0] size);
    return (size == 0) ? 8 : ((size == 1) ? 16 : 32);
  endfunction

  function automatic bit isMis(input logic [1:0] size, input int lo);
    return size == 3 || (size == 1 && lo % 2 != 0) ||
           (size == 2 && lo != 0);
  endfunction

  function automatic logic [31:0] expLoad(input logic [31:0] word,
      input logic [1:0] size, input bit uns, input int lo);
    longint bits = longint'(widthOf(size));
    longint v = (longint'(word) >> (8 * lo)) & ((64'sd1 << bits) - 1);
    if (!uns && v >= (64'sd1 << (bits - 1))) v -= (64'sd1 << bits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] expStore(input logic [31:0] old,
      input logic [31:0] data, input logic [1:0] size, input int lo);
    longint bits = longint'(widthOf(size));
    longint mask = ((64'sd1 << bits) - 1) << (8 * lo);
    longint v = (longint'(old) & ~mask) |
                ((longint'(data) << (8 * lo)) & mask);
    return v[31:0];
  endfunction

  // Called just after the accept edge; returns at the response cycle.
  task automatic observe(input string tag, input bit w,
      input logic [1:0] size, input bit uns, input logic [31:0] addr,
      input logic [31:0] wdata, output logic [31:0] got);
    int wi = int'(addr[AW+1:2]);
    int lo = int'(addr[1:0]);
    bit mis = isMis(size, lo);
    logic [31:0] oldWord = shadow.exists(wi) ? shadow[wi] : 32'h0;
    logic [31:0] newWord = expStore(oldWord, wdata, size, lo);
    int expLat, expWrCyc;
    logic [31:0] expData = '0;
    int lat = 0, wrCnt = 0, wrCyc = -1;
    logic [31:0] wrData = '0, wrAddr = '0;
    logic err = 1'b0;
    got = '0;
    if (mis)                 begin expLat = 1; expWrCyc = -1; end
    else if (!w)             begin expLat = 3; expWrCyc = -1;
                                   expData = expLoad(oldWord, size, uns, lo); end
    else if (size == 2)      begin expLat = 2; expWrCyc = 1; end
    else                     begin expLat = 4; expWrCyc = 3; end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk({tag, ".busy"}, {31'b0, req_ready}, 32'd0);
      if (mem_write) begin
        wrCnt++; wrCyc = k; wrData = mem_wdata;
        wrAddr = {{(32-AW){1'b0}}, mem_addr};
      end
      if (rsp_valid) begin
        lat = k; got = rsp_rdata; err = rsp_err;
        break;
      end
      @(posedge clock);
    end
    chk({tag, ".lat"}, lat, expLat);
    chk({tag, ".err"}, {31'b0, err}, {31'b0, mis});
    chk({tag, ".rdata"}, got, expData);
    chk({tag, ".wrcnt"}, wrCnt, (expWrCyc > 0) ? 1 : 0);
    if (expWrCyc > 0) begin
      chk({tag, ".wrcyc"}, wrCyc, expWrCyc);
      chk({tag, ".wrdata"}, wrData, newWord);
      chk({tag, ".wraddr"}, wrAddr, wi);
      shadow[wi] = newWord;
    end
  endtask

  task automatic drive(input bit w, input logic [1:0] size,
      input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_write = w; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic doTxn(input string tag, input bit w,
      input logic [1:0] size, input bit uns, input logic [31:0] addr,
      input logic [31:0] wdata, output logic [31:0] got);
    @(negedge clock);
    chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    drive(w, size, uns, addr, wdata);
    @(posedge clock);
    #1 req_valid = 1'b0;
    observe(tag, w, size, uns, addr, wdata, got);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.ready", {31'b0, req_ready}, 32'd1);
    chk("rst.rspv", {31'b0, rsp_valid}, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.err", {31'b0, rsp_err}, 32'd0);
    chk("rst.maddr", {{(32-AW){1'b0}}, mem_addr}, 32'd0);
    chk("rst.mwdata", mem_wdata, 32'd0);
    chk("rst.mwrite", {31'b0, mem_write}, 32'd0);
    reset = 1'b0;

    doTxn("sw1", 1, 2, 0, 32'h0000_0008, 32'hA000_00F5, got);
    doTxn("lw1", 0, 2, 0, 32'h0000_0008, 32'h0, got);
    chk("lw1.const", got, 32'hA000_00F5);

    doTxn("sw2", 1, 2, 0, 32'h0000_0008, 32'h1122_3344, got);
    doTxn("sb2", 1, 0, 0, 32'h0000_000A, 32'h0000_00F5, got);
    doTxn("lw2", 0, 2, 0, 32'h0000_0008, 32'h0, got);
    chk("lw2.const", got, 32'h11F5_3344);

    doTxn("sw3", 1, 2, 0, 32'h0000_0000, 32'h80FF_7F01, got);
    doTxn("lb", 0, 0, 0, 32'h0000_0002, 32'h0, got);
    chk("lb.const", got, 32'hFFFF_FFFF);
    doTxn("lbu", 0, 0, 1, 32'h0000_0002, 32'h0, got);
    chk("lbu.const", got, 32'h0000_00FF);
    doTxn("lh", 0, 1, 0, 32'h0000_0002, 32'h0, got);
    chk("lh.const", got, 32'hFFFF_80FF);
    doTxn("lhu", 0, 1, 1, 32'h0000_0000, 32'h0, got);
    chk("lhu.const", got, 32'h0000_7F01);

    doTxn("mis.lw", 0, 2, 0, 32'h0000_0006, 32'h0, got);
    doTxn("mis.sh", 1, 1, 0, 32'h0000_0003, 32'h0000_ABCD, got);
    doTxn("mis.sz3", 1, 3, 0, 32'h0000_0000, 32'h1234_5678, got);
    doTxn("mis.rd0", 0, 2, 0, 32'h0000_0000, 32'h0, got);
    chk("mis.rd0.const", got, 32'h80FF_7F01);

    // Load held valid, second request waiting behind it.
    @(negedge clock);
    drive(0, 2, 0, 32'h0000_0008, 32'h0);
    @(posedge clock);
    #1 drive(1, 2, 0, 32'h0001_0004, 32'hDEAD_BEEF);
    observe("busy.lw", 0, 2, 0, 32'h0000_0008, 32'h0, got);
    @(negedge clock);
    chk("busy.idle", {31'b0, req_ready}, 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    observe("alias.sw", 1, 2, 0, 32'h0001_0004, 32'hDEAD_BEEF, got);
    doTxn("alias.lw", 0, 2, 0, 32'h0000_0004, 32'h0, got);
    chk("alias.const", got, 32'hDEAD_BEEF);

    // Reset asserted during CAPTURE of a byte store.
    @(negedge clock);
    drive(1, 0, 0, 32'h0000_0009, 32'h0000_0077);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("rstop.mwrite", {31'b0, mem_write}, 32'd0);
      chk("rstop.rspv", {31'b0, rsp_valid}, 32'd0);
      chk("rstop.ready", {31'b0, req_ready}, 32'd1);
    end
    doTxn("rstop.lw", 0, 2, 0, 32'h0000_0008, 32'h0, got);
    chk("rstop.const", got, 32'h11F5_3344);

    for (int i = 0; i < 8; i++)
      doTxn("init", 1, 2, 0, 32'(i * 4), $urandom, got);
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_0000) |
          32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
      doTxn("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom, got);
    end
    @(negedge clock);
    for (int i = 0; i < 8; i++)
      chk("final.mem", dmem[i], shadow[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the dmemory32 data-memory port; sits between the CPU load/store path and dmemory32.
- Converts byte, halfword and word load/store requests into word-wide memory transactions.
- Loads: aligned word read plus lane extraction with sign/zero extension.
- Sub-word stores: read-modify-write sequence.
- Misaligned requests: flagged as errors and never touch memory.

Parameters:
- MEM_AW, 14, word-address width presented to dmemory32. mem_addr = req_addr[MEM_AW+1:2]; upper address bits are ignored, so addresses alias.

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as misaligned
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, taken from the low bits (byte [7:0], half [15:0])
- rsp_valid  out  1  one-cycle pulse marking completion
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid; misaligned or invalid-size request
- mem_addr  out  MEM_AW  word address to dmemory32, registered
- mem_wdata  out  32  write word, registered
- mem_write  out  1  write enable, registered, one cycle per write
- mem_rdata  in  32  dmemory32 read data, valid one cycle after mem_addr is presented (synchronous read)

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=0, mem_wdata=0, mem_write=0.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; half h = bits [16h+15:16h], h=addr[1].
- Alignment:
  - byte: always aligned
  - half: addr[0]==0
  - word: addr[1:0]==0
  - size 3: error
- States and transitions (T = accept cycle):
  - IDLE: req_ready=1. On accept, latch all request fields, then:
    - misaligned -> ERR
    - word store -> WR
    - otherwise -> ISSUE
  - ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0; mem_write stays 0 -> IDLE. Response at T+1.
  - WR: mem_addr and mem_wdata=req_wdata presented, mem_write=1 -> RESP. Word-store response at T+2.
  - ISSUE: mem_addr presented, mem_write=0 -> CAPTURE.
  - CAPTURE: sample mem_rdata into an internal word register.
    - load -> RESP, with rsp_rdata = lane extract + extension. Load response at T+3.
    - sub-word store -> MERGE.
  - MERGE: mem_wdata = captured word with the target lane replaced by req_wdata's low byte/half; other lanes unchanged; mem_write=1 -> RESP. Sub-word store response at T+4.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. req_ready returns to 1 the following cycle.
- mem_write is asserted only in WR and MERGE, never more than one cycle per request.
- mem_addr holds its last value between requests.
- Requests while busy: ignored (req_ready=0); the unit has no queue, so the requester must hold its request.
- Back-to-back: a new request can be accepted in the IDLE cycle right after RESP; there is no overlap.
- Reset mid-operation: state returns to IDLE on the next edge; any pending write is aborted (mem_write=0 after that edge); no rsp_valid is produced for the aborted request.
  - A reset in the MERGE cycle does not retract the write already registered for that edge.
- Extension:
  - signed byte: {24{b[7]},b}
  - signed half: {16{h[15]},h}
  - unsigned: zero fill
  - word loads: unmodified

Test Plan:
- Word store then load: store 0xA000_00F5 at 0x0000_0008 -> mem_write=1 at T+1 with mem_addr=2, rsp_valid at T+2. Load word 0x0000_0008 -> rsp_rdata=0xA000_00F5 at T+3, rsp_err=0.
- Byte store RMW: memory word 2 = 0x1122_3344; store byte 0xF5 at 0x0000_000A -> exactly one mem_write at T+3 with mem_wdata=0x11F5_3344; word reread gives 0x11F5_3344.
- Loads with extension, word = 0x80FF_7F01:
  - lb addr 2 -> 0xFFFF_FFFF; lbu addr 2 -> 0x0000_00FF
  - lh addr 2 -> 0xFFFF_80FF; lhu addr 0 -> 0x0000_7F01
- Misaligned and invalid requests: lw at 0x0000_0006, sh at 0x0000_0003, size=3 -> each gives rsp_valid with rsp_err=1 at T+1, rsp_rdata=0, and no mem_write. Memory is unchanged on reread.
- Busy and aliasing: hold req_valid through a load, with a second request queued behind it -> second accepted only in the IDLE cycle after RESP. Store word 0xDEAD_BEEF to 0x0001_0004 (MEM_AW=14) -> word 1 written; load 0x0000_0004 returns 0xDEAD_BEEF.
- Reset mid-op: assert reset during the CAPTURE cycle of a byte store -> no mem_write and no rsp_valid; req_ready=1 after reset releases; memory word unchanged.
